// File: rtl/uart_receiver.sv
// 8-data + even-parity + 1-stop UART receiver with 16x oversampling from clk.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 voting over samples 7, 8 and 9.
module uart_receiver #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    input  logic [2:0] baud_sel,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    function automatic logic [13:0] divisor(input logic [2:0] sel);
        int baud;
        baud = 300;
        case (sel)
            3'd0: baud = 300;
            3'd1: baud = 1200;
            3'd2: baud = 4800;
            3'd3: baud = 9600;
            3'd4: baud = 19200;
            3'd5: baud = 38400;
            3'd6: baud = 57600;
            3'd7: baud = 115200;
        endcase
        // Rounded division: adding half the denominator before truncating.
        return 14'((CLK_FREQ_HZ + 8 * baud) / (16 * baud));
    endfunction

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_prev, armed, start_edge;
    logic [2:0]             state, baud_q, bit_cnt;
    logic [13:0]            tick_cnt, div;
    logic                   tick, decide, bit_val, par_bit;
    logic [3:0]             sample_cnt, pos;
    logic [7:0]             shift;
    logic                   frame_perr, frame_ferr;

    assign rx_s       = sync[SYNC_STAGES-1];
    assign div        = divisor(baud_q);
    assign tick       = (tick_cnt == div - 14'd1);
    assign pos        = sample_cnt + 4'd1;
    assign start_edge = armed && rx_prev && !rx_s;

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [3:0] DECIDE_POS = 4'd9;
    logic v7, v8;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v7 <= 1'b0;
            v8 <= 1'b0;
        end else if (tick) begin
            if (pos == 4'd7) v7 <= rx_s;
            if (pos == 4'd8) v8 <= rx_s;
        end
    end

    assign bit_val = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);
`else
    localparam logic [3:0] DECIDE_POS = 4'd8;
    assign bit_val = rx_s;
`endif

    // Sample position runs continuously mod 16 from the start edge, so every bit
    // is decided at the same offset within its own bit period.
    assign decide     = tick && (pos == DECIDE_POS);
    assign frame_perr = (^shift) != par_bit;
    assign frame_ferr = !bit_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync       <= '1;
            rx_prev    <= 1'b1;
            armed      <= 1'b1;
            state      <= IDLE;
            baud_q     <= 3'd0;
            tick_cnt   <= 14'd0;
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            Rx_DATA    <= 8'h00;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
            Rx_BUSY    <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], RxD};
            rx_prev   <= rx_s;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            tick_cnt  <= tick ? 14'd0 : tick_cnt + 14'd1;
            if (state != IDLE && tick) sample_cnt <= pos;

            if (!Rx_EN) begin
                state   <= IDLE;
                Rx_BUSY <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A break leaves the line low; wait for it to return high.
                        if (rx_s) armed <= 1'b1;
                        baud_q <= baud_sel;
                        if (baud_sel != baud_q) tick_cnt <= 14'd0;
                        if (start_edge) begin
                            state      <= START;
                            sample_cnt <= 4'd0;
                            tick_cnt   <= 14'd0;
                        end
                    end
                    START: if (decide) begin
                        if (!bit_val) begin
                            state   <= DATA;
                            Rx_BUSY <= 1'b1;
                            bit_cnt <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DATA: if (decide) begin
                        shift   <= {bit_val, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: if (decide) begin
                        par_bit <= bit_val;
                        state   <= STOP;
                    end
                    STOP: if (decide) begin
                        Rx_DATA   <= shift;
                        Rx_PERROR <= frame_perr;
                        Rx_FERROR <= frame_ferr;
                        Rx_VALID  <= !frame_perr && !frame_ferr;
                        armed     <= bit_val;
                        Rx_BUSY   <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected results,
// a monitor pops and compares on every Rx_VALID/Rx_PERROR/Rx_FERROR pulse.
module tb_uart_receiver;

    // 12.5 MHz keeps the 9600-baud frames short: divisors 7 (112 clk/bit) and 81 (1296 clk/bit).
    localparam int BIT_FAST = 112;
    localparam int BIT_SLOW = 1296;

    logic       clk = 1'b0;
    logic       reset, Rx_EN, RxD;
    logic [2:0] baud_sel;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

    always #10 clk = ~clk;

    uart_receiver #(.CLK_FREQ_HZ(12_500_000), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .RxD(RxD), .baud_sel(baud_sel),
        .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR),
        .Rx_FERROR(Rx_FERROR), .Rx_BUSY(Rx_BUSY)
    );

    typedef struct packed {
        logic       v;
        logic       p;
        logic       f;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic watch_busy = 1'b0;
    logic busy_seen = 1'b0;

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic v, input logic p, input logic f, input logic [7:0] d);
        exp_t e;
        e.v = v; e.p = p; e.f = f; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp, input int bclk);
        logic [10:0] fr;
        fr = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            RxD = fr[i];
            clks(bclk);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t got, e;
        if (watch_busy && Rx_BUSY) busy_seen = 1'b1;
        if (!reset && (Rx_VALID || Rx_PERROR || Rx_FERROR)) begin
            got.v = Rx_VALID; got.p = Rx_PERROR; got.f = Rx_FERROR; got.d = Rx_DATA;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got v=%b p=%b f=%b data=%h, expected no pulse",
                         got.v, got.p, got.f, got.d);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL frame: got v=%b p=%b f=%b data=%h, expected v=%b p=%b f=%b data=%h",
                             got.v, got.p, got.f, got.d, e.v, e.p, e.f, e.d);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; Rx_EN = 1'b1; RxD = 1'b1; baud_sel = 3'b111;
        clks(5);
        @(negedge clk);
        check("reset_data",   Rx_DATA,   8'h00);
        check("reset_valid",  Rx_VALID,  0);
        check("reset_perror", Rx_PERROR, 0);
        check("reset_ferror", Rx_FERROR, 0);
        check("reset_busy",   Rx_BUSY,   0);
        reset = 1'b0;
        clks(20);

        // Good frame, then a parity error (0x01 needs parity 1).
        expect_frame(1, 0, 0, 8'hA5); send(8'hA5, 1'b0, 1'b1, BIT_FAST); clks(2 * BIT_FAST);
        expect_frame(0, 1, 0, 8'h01); send(8'h01, 1'b0, 1'b1, BIT_FAST); clks(2 * BIT_FAST);

        // Framing error, line back high, then a good frame.
        expect_frame(0, 0, 1, 8'h3C); send(8'h3C, 1'b0, 1'b0, BIT_FAST);
        RxD = 1'b1; clks(2 * BIT_FAST);
        expect_frame(1, 0, 0, 8'h55); send(8'h55, 1'b0, 1'b1, BIT_FAST); clks(2 * BIT_FAST);

        // Glitch shorter than half a bit (56 clk) must be rejected.
        watch_busy = 1'b1;
        RxD = 1'b0; clks(25); RxD = 1'b1; clks(300);
        watch_busy = 1'b0;
        check("false_start_busy", busy_seen, 0);

        // Back-to-back frames at 9600.
        baud_sel = 3'b011; clks(100);
        expect_frame(1, 0, 0, 8'hFF);
        expect_frame(1, 0, 0, 8'h00);
        send(8'hFF, 1'b0, 1'b1, BIT_SLOW);
        send(8'h00, 1'b0, 1'b1, BIT_SLOW);
        clks(2 * BIT_SLOW);
        check("b2b_drained", exp_q.size(), 0);

        // Disable in the middle of data bit 4; that frame produces nothing.
        baud_sel = 3'b111; clks(2 * BIT_FAST);
        fork
            send(8'hC3, 1'b0, 1'b1, BIT_FAST);
            begin
                clks(5 * BIT_FAST + BIT_FAST / 2);
                check("busy_mid_frame", Rx_BUSY, 1);
                Rx_EN = 1'b0;
                @(posedge clk); @(negedge clk);
                check("busy_after_disable", Rx_BUSY, 0);
                check("data_held", Rx_DATA, 8'h00);
            end
        join
        clks(2 * BIT_FAST);
        Rx_EN = 1'b1; clks(20);
        expect_frame(1, 0, 0, 8'h81); send(8'h81, 1'b0, 1'b1, BIT_FAST); clks(2 * BIT_FAST);

        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) clks(1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
